counter_updown_mod: RTL

Parametrised synchronous up/down counter with programmable limit, parallel load, synchronous clear and selectable wrap or saturate behaviour. It generalises the fixed-width free-running enable counter used across the lab designs. It is the standard counting element for timers, clock dividers and address generators. A registered terminal-count pulse lets downstream blocks cascade or trigger on boundary events.

---
 rtl/counter_updown_mod.sv | 76 +++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable inclusive limit, parallel load,
// synchronous clear and wrap/saturate boundary behaviour. A registered
// terminal-count pulse marks every enabled step that hits a boundary.
module counter_updown_mod #(
    parameter int unsigned BIT_SZ    = 10,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_value,
    input  logic              up,
    input  logic              saturate,
    input  logic [BIT_SZ-1:0] limit,
    output logic [BIT_SZ-1:0] count,
    output logic              tc,
    output logic              at_zero,
    output logic              at_limit
);

    localparam logic [BIT_SZ-1:0] CNT_RST = BIT_SZ'(RESET_VAL);
    localparam logic [BIT_SZ-1:0] CNT_ONE = BIT_SZ'(1);

    logic [BIT_SZ-1:0] count_q, count_d;
    logic              tc_q, tc_d;

    // Next count and terminal-count: clear beats load beats enable.
    // Boundary checks come before the +/-1 so the arithmetic never overflows.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
        end else if (enable) begin
            if (up) begin
                if (count_q >= limit) begin
                    count_d = saturate ? limit : '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                if (count_q > limit) begin
                    // limit was lowered below the current count: snap into range
                    count_d = limit;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    count_d = saturate ? '0 : limit;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    // Count and tc registers, asynchronously reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= CNT_RST;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign at_zero  = (count_q == '0);
    assign at_limit = (count_q == limit);

endmodule
